// File: rtl/onehot_pkg.sv
// rtl/onehot_pkg.sv - shared error-counter constants and per-lane result type for onehot_enc_pipe
package onehot_pkg;

  localparam int              ERR_W     = 8;
  localparam logic [ERR_W-1:0] ERR_MAX   = 8'd255;
  // Wide enough for the largest legal lane (256 bits -> 8-bit index).
  localparam int              BIN_MAX_W = 8;

  typedef struct packed {
    logic [BIN_MAX_W-1:0] bin;
    logic                 zero;
    logic                 multi;
  } lane_res_t;

endpackage

// File: rtl/onehot_enc_lane.sv
// rtl/onehot_enc_lane.sv - combinational one-hot to binary encoder for one lane (multi detect under ONEHOT_ENC_PIPE_CHECK_EN)
module onehot_enc_lane
  import onehot_pkg::*;
#(
  parameter int ONEHOT_WIDTH = 16
) (
  input  logic [ONEHOT_WIDTH-1:0] onehot,
  output lane_res_t               res
);

  always_comb begin
    res = '0;
    // OR of all set indices: exact for one-hot, defined fallback for multi-hot.
    for (int i = 0; i < ONEHOT_WIDTH; i++) begin
      if (onehot[i]) res.bin = res.bin | BIN_MAX_W'(i);
    end
    res.zero = (onehot == '0);
`ifdef ONEHOT_ENC_PIPE_CHECK_EN
    res.multi = ((onehot & (onehot - ONEHOT_WIDTH'(1))) != '0);
`endif
  end

endmodule

// File: rtl/onehot_enc_pipe.sv
// rtl/onehot_enc_pipe.sv - multi-lane one-hot encoder behind a 2-entry skid FIFO; ONEHOT_ENC_PIPE_CHECK_EN adds multi-hot detect and err_count
module onehot_enc_pipe
  import onehot_pkg::*;
#(
  parameter int ONEHOT_WIDTH = 16,
  parameter int CHANNELS     = 4,
  parameter int BIN_WIDTH    = $clog2(ONEHOT_WIDTH)
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [CHANNELS*ONEHOT_WIDTH-1:0] in_onehot,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [CHANNELS*BIN_WIDTH-1:0]    out_bin,
  output logic [CHANNELS-1:0]              out_zero,
  output logic [CHANNELS-1:0]              out_multi,
  output logic [ERR_W-1:0]                 err_count
);

  localparam int BW_ALL = CHANNELS * BIN_WIDTH;
`ifdef ONEHOT_ENC_PIPE_CHECK_EN
  localparam int PW = BW_ALL + 2 * CHANNELS;
`else
  localparam int PW = BW_ALL + CHANNELS;
`endif

  logic [BW_ALL-1:0]   enc_bin;
  logic [CHANNELS-1:0] enc_zero;
  logic [CHANNELS-1:0] enc_multi;
  logic [PW-1:0]       enc_pl;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    lane_res_t res;
    logic      unused_res_bits;
    onehot_enc_lane #(.ONEHOT_WIDTH(ONEHOT_WIDTH)) u_lane (
      .onehot (in_onehot[c*ONEHOT_WIDTH +: ONEHOT_WIDTH]),
      .res    (res)
    );
    assign enc_bin[c*BIN_WIDTH +: BIN_WIDTH] = res.bin[BIN_WIDTH-1:0];
    assign enc_zero[c]                       = res.zero;
    assign enc_multi[c]                      = res.multi;
    assign unused_res_bits                   = ^res.bin;
  end

`ifdef ONEHOT_ENC_PIPE_CHECK_EN
  assign enc_pl = {enc_multi, enc_zero, enc_bin};
`else
  logic unused_multi;
  assign unused_multi = ^enc_multi;
  assign enc_pl       = {enc_zero, enc_bin};
`endif

  logic [PW-1:0] head_q, head_d, skid_q, skid_d;
  logic [1:0]    count_q, count_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          push, pop;

  // head_q always holds the oldest beat, so the outputs come straight from flops.
  always_comb begin
    push        = in_valid & in_ready_q;
    pop         = out_valid_q & out_ready;
    head_d      = head_q;
    skid_d      = skid_q;
    count_d     = count_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = enc_pl;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = enc_pl;
        end else if (push) begin
          skid_d  = enc_pl;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_d  = skid_q;
          skid_d  = enc_pl;
          count_d = push ? 2'd2 : 2'd1;
        end
      end
    endcase
    in_ready_d  = (count_d < 2'd2);
    out_valid_d = (count_d != 2'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q      <= '0;
      skid_q      <= '0;
      count_q     <= 2'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      skid_q      <= skid_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_bin   = head_q[BW_ALL-1:0];
  assign out_zero  = head_q[BW_ALL +: CHANNELS];

`ifdef ONEHOT_ENC_PIPE_CHECK_EN
  logic [ERR_W-1:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (push && (|enc_multi) && (err_q != ERR_MAX)) err_d = err_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= '0;
    else          err_q <= err_d;
  end

  assign out_multi = head_q[BW_ALL + CHANNELS +: CHANNELS];
  assign err_count = err_q;
`else
  assign out_multi = '0;
  assign err_count = '0;
`endif

endmodule
